bcd_seq_converter: RTL and testbench

Sequential 12-bit binary to 4-digit BCD converter using shift-add-3 (double dabble), one bit per clock. It sits between the 0–4095 counter and the display status register. It accepts a binary sample on a start strobe and presents packed BCD with a one-cycle ready pulse. That pulse is the `rdy` that gates the capture of `bcd_d_out` into the 16-bit display status register.

---
 rtl/bcd_seq_converter.sv | 100 ++++++++++
 tb/tb_bcd_seq_converter.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq_converter.sv
// Sequential binary-to-BCD converter (double dabble), one bit per mclk.
// Accepts a sample on en in IDLE and presents packed BCD with a one-cycle rdy pulse.
module bcd_seq_converter #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic                  mclk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [BIN_W-1:0]      bin_d_in,
  output logic [4*DIGITS-1:0]   bcd_d_out,
  output logic                  rdy,
  output logic                  busy
);

  localparam int BCD_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state, state_nxt;
  logic [BIN_W-1:0]   bin_sh, bin_sh_nxt;
  logic [BCD_W-1:0]   scratch, scratch_nxt;
  logic [CNT_W-1:0]   bitcnt, bitcnt_nxt;
  logic [BCD_W-1:0]   bcd_nxt;
  logic               rdy_nxt;
  logic               busy_nxt;
  logic [BCD_W-1:0]   adjusted;

  // Add-3 correction on every digit in parallel, ahead of the shift
  always_comb begin
    adjusted = scratch;
    for (int d = 0; d < DIGITS; d++) begin
      if (scratch[4*d +: 4] >= 4'd5) begin
        adjusted[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    bin_sh_nxt  = bin_sh;
    scratch_nxt = scratch;
    bitcnt_nxt  = bitcnt;
    bcd_nxt     = bcd_d_out;
    rdy_nxt     = 1'b0;
    busy_nxt    = busy;
    case (state)
      IDLE: begin
        if (en) begin
          bin_sh_nxt  = bin_d_in;
          scratch_nxt = '0;
          bitcnt_nxt  = '0;
          busy_nxt    = 1'b1;
          state_nxt   = SHIFT;
        end
      end
      SHIFT: begin
        scratch_nxt = {adjusted[BCD_W-2:0], bin_sh[BIN_W-1]};
        bin_sh_nxt  = {bin_sh[BIN_W-2:0], 1'b0};
        bitcnt_nxt  = bitcnt + CNT_W'(1);
        // Final step publishes the freshly shifted value so nothing partial leaks out
        if (bitcnt == LAST_STEP) begin
          bcd_nxt   = {adjusted[BCD_W-2:0], bin_sh[BIN_W-1]};
          rdy_nxt   = 1'b1;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      bin_sh    <= '0;
      scratch   <= '0;
      bitcnt    <= '0;
      bcd_d_out <= '0;
      rdy       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nxt;
      bin_sh    <= bin_sh_nxt;
      scratch   <= scratch_nxt;
      bitcnt    <= bitcnt_nxt;
      bcd_d_out <= bcd_nxt;
      rdy       <= rdy_nxt;
      busy      <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_bcd_seq_converter.sv
// Scoreboard bench for bcd_seq_converter: a countdown model predicts rdy/busy timing,
// expected BCD comes from decimal arithmetic and is popped by a monitor on each rdy.
module tb_bcd_seq_converter;

  logic        mclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] bin_d_in = '0;
  logic [15:0] bcd_d_out;
  logic        rdy;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_q[$];
  int          remaining = 0;
  logic        m_rdy = 1'b0;
  logic        m_busy = 1'b0;
  logic [15:0] m_held = '0;
  logic [15:0] m_pending = '0;

  bcd_seq_converter #(.BIN_W(12), .DIGITS(4)) dut (
    .mclk      (mclk),
    .rst_n     (rst_n),
    .en        (en),
    .bin_d_in  (bin_d_in),
    .bcd_d_out (bcd_d_out),
    .rdy       (rdy),
    .busy      (busy)
  );

  always #5 mclk = ~mclk;

  function automatic logic [15:0] ref_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual,
                             input logic [15:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      if (errors <= 40)
        $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: a conversion takes 12 edges after acceptance; en only counts when idle
  always @(posedge mclk or negedge rst_n) begin
    if (!rst_n) begin
      remaining <= 0;
      m_rdy     <= 1'b0;
      m_busy    <= 1'b0;
      m_held    <= '0;
      exp_q.delete();
    end else if (remaining == 0) begin
      m_rdy <= 1'b0;
      if (en) begin
        remaining <= 12;
        m_busy    <= 1'b1;
        m_pending <= ref_bcd(int'(bin_d_in));
        exp_q.push_back(ref_bcd(int'(bin_d_in)));
      end
    end else begin
      remaining <= remaining - 1;
      if (remaining == 1) begin
        m_rdy  <= 1'b1;
        m_busy <= 1'b0;
        m_held <= m_pending;
      end else begin
        m_rdy <= 1'b0;
      end
    end
  end

  always @(negedge mclk) begin
    if (rst_n) begin
      checkOutput("rdy", {15'd0, rdy}, {15'd0, m_rdy});
      checkOutput("busy", {15'd0, busy}, {15'd0, m_busy});
      checkOutput("bcd_hold", bcd_d_out, m_held);
      if (rdy) begin
        if (exp_q.size() == 0) begin
          checkOutput("rdy_without_request", 16'd1, 16'd0);
        end else begin
          checkOutput("bcd_result", bcd_d_out, exp_q.pop_front());
        end
      end
    end
  end

  // One en pulse with value, then gap idle cycles beyond the 12-step conversion
  task automatic applyStimulus(input logic [11:0] value, input int gap, input bit noisy);
    @(negedge mclk);
    en = 1'b1;
    bin_d_in = value;
    @(negedge mclk);
    en = 1'b0;
    for (int i = 0; i < 11 + gap; i++) begin
      if (noisy) begin
        bin_d_in = 12'($urandom);
        en = ($urandom_range(0, 3) == 0) && (i < 10);
      end
      @(negedge mclk);
    end
    en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    repeat (3) @(negedge mclk);
    #1;
    checkOutput("reset_bcd", bcd_d_out, 16'h0000);
    checkOutput("reset_rdy", {15'd0, rdy}, 16'd0);
    checkOutput("reset_busy", {15'd0, busy}, 16'd0);
    @(negedge mclk);
    #2 rst_n = 1'b1;

    applyStimulus(12'd0, 1, 1'b0);
    applyStimulus(12'd4095, 0, 1'b0);
    applyStimulus(12'd1234, 0, 1'b0);
    applyStimulus(12'd9, 2, 1'b0);
    applyStimulus(12'd1000, 0, 1'b0);

    // en re-asserted in each rdy cycle: exhaustive sweep with 13-cycle period
    @(negedge mclk);
    en = 1'b1;
    for (int v = 0; v < 4096; v++) begin
      bin_d_in = 12'(v);
      repeat (13) @(negedge mclk);
    end
    en = 1'b0;
    repeat (14) @(negedge mclk);

    // Mid-conversion en with a different value is ignored
    @(negedge mclk);
    en = 1'b1;
    bin_d_in = 12'd100;
    @(negedge mclk);
    en = 1'b0;
    repeat (4) @(negedge mclk);
    en = 1'b1;
    bin_d_in = 12'd777;
    @(negedge mclk);
    en = 1'b0;
    repeat (20) @(negedge mclk);

    // Reset mid-conversion discards the partial result
    applyStimulus(12'd2048, 1, 1'b0);
    @(negedge mclk);
    en = 1'b1;
    bin_d_in = 12'd3071;
    @(negedge mclk);
    en = 1'b0;
    repeat (5) @(negedge mclk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midreset_bcd", bcd_d_out, 16'h0000);
    checkOutput("midreset_rdy", {15'd0, rdy}, 16'd0);
    checkOutput("midreset_busy", {15'd0, busy}, 16'd0);
    @(negedge mclk);
    #2 rst_n = 1'b1;
    repeat (16) @(negedge mclk);
    applyStimulus(12'd55, 1, 1'b0);

    // Continuous en: pulses every 13 cycles, output stable in between
    @(negedge mclk);
    en = 1'b1;
    bin_d_in = 12'd321;
    repeat (13 * 5) @(negedge mclk);
    en = 1'b0;
    repeat (14) @(negedge mclk);

    // Randomized values, gaps and ignored en/bin_d_in noise during conversions
    for (int n = 0; n < 200; n++) begin
      applyStimulus(12'($urandom_range(0, 4095)), $urandom_range(0, 3), 1'b1);
    end
    repeat (16) @(negedge mclk);

    checkOutput("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
